// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants, FSM and phase encodings for the HUB75 scanner
package led_pkg;

  localparam int PANEL_W = 64;
  localparam int HALF_H  = 32;

  localparam int IDX_DATA = 0;
  localparam int IDX_ADDR = 6;
  localparam int IDX_LCLK = 11;
  localparam int IDX_LAT  = 12;
  localparam int IDX_OE_N = 13;

  localparam int TAIL_CYCLES  = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int CNT_W        = 16;

  typedef enum logic [2:0] {
    ST_SHIFT = 3'd0,
    ST_TAIL  = 3'd1,
    ST_BLANK = 3'd2,
    ST_LATCH = 3'd3,
    ST_ON    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PH_P0 = 2'd0,
    PH_P1 = 2'd1,
    PH_P2 = 2'd2,
    PH_P3 = 2'd3
  } phase_e;

endpackage

// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - HUB75 64x64 scan initiator: painter queries, column shift, latch, display
// Optional macro LED_SCANNER_BRIGHTNESS_EN adds a brightness input that trims OE_N low time in ON.
module led_scanner
  import led_pkg::*;
#(
  parameter int SUBFRAMES = 8,
  parameter int ON_CYCLES = 64
) (
  input  logic        clk,
  input  logic        resetn,
`ifdef LED_SCANNER_BRIGHTNESS_EN
  input  logic [2:0]  brightness,
`endif
  output logic [12:0] frame,
  output logic [7:0]  subframe,
  output logic [5:0]  x,
  output logic [5:0]  y,
  input  logic [2:0]  rgb,
  output logic [15:0] LED_PANEL
);

  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(ON_CYCLES - 1);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [5:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        subframe_q, subframe_d;
  logic [12:0]       frame_q, frame_d;
  logic [2:0]        top_q, top_d;
  logic [5:0]        data_q, data_d;
  logic [4:0]        addr_q, addr_d;
  logic              lclk_q, lclk_d;
  logic              lat_q, lat_d;
  logic              oe_n_q, oe_n_d;
`ifdef LED_SCANNER_BRIGHTNESS_EN
  logic [CNT_W-1:0]  on_len_q, on_len_d;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    subframe_d = subframe_q;
    frame_d    = frame_q;
    top_d      = top_q;
    data_d     = data_q;
    addr_d     = addr_q;
`ifdef LED_SCANNER_BRIGHTNESS_EN
    on_len_d   = on_len_q;
`endif
    case (state_q)
      ST_SHIFT: begin
        phase_d = phase_e'(phase_q + 2'd1);
        if (phase_q == PH_P1) top_d = rgb;
        // bottom half-row pixel arrives in P2 and goes straight to the pins with the top
        if (phase_q == PH_P2) data_d = {rgb, top_q};
        if (phase_q == PH_P3) begin
          col_d = col_q + 6'd1;
          if (col_q == 6'(PANEL_W - 1)) begin
            state_d = ST_TAIL;
            cnt_d   = '0;
          end
        end
      end
      ST_TAIL: begin
        if (cnt_q == CNT_W'(TAIL_CYCLES - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          addr_d  = row_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        state_d = ST_ON;
        cnt_d   = '0;
`ifdef LED_SCANNER_BRIGHTNESS_EN
        on_len_d = CNT_W'(((32'(brightness) + 32'd1) * 32'(ON_CYCLES)) >> 3);
`endif
      end
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          row_d   = row_q + 5'd1;
          if (row_q == 5'(HALF_H - 1)) begin
            if (subframe_q == 8'(SUBFRAMES - 1)) begin
              subframe_d = 8'd0;
              frame_d    = frame_q + 13'd1;
            end else begin
              subframe_d = subframe_q + 8'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SHIFT;
    endcase

    // panel strobes are registered from the next state so they line up with the state they describe
    lclk_d = 1'b0;
    if ((state_d == ST_SHIFT) && (col_d != 6'd0) && ((phase_d == PH_P1) || (phase_d == PH_P2)))
      lclk_d = 1'b1;
    if ((state_d == ST_TAIL) && ((cnt_d == CNT_W'(1)) || (cnt_d == CNT_W'(2))))
      lclk_d = 1'b1;
    lat_d = (state_d == ST_LATCH);
`ifdef LED_SCANNER_BRIGHTNESS_EN
    oe_n_d = !((state_d == ST_ON) && (cnt_d < on_len_d));
`else
    oe_n_d = (state_d != ST_ON);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_SHIFT;
      phase_q    <= PH_P0;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      subframe_q <= '0;
      frame_q    <= '0;
      top_q      <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      lclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
`ifdef LED_SCANNER_BRIGHTNESS_EN
      on_len_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      subframe_q <= subframe_d;
      frame_q    <= frame_d;
      top_q      <= top_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      lclk_q     <= lclk_d;
      lat_q      <= lat_d;
      oe_n_q     <= oe_n_d;
`ifdef LED_SCANNER_BRIGHTNESS_EN
      on_len_q   <= on_len_d;
`endif
    end
  end

  always_comb begin
    LED_PANEL                  = '0;
    LED_PANEL[IDX_DATA +: 6]   = data_q;
    LED_PANEL[IDX_ADDR +: 5]   = addr_q;
    LED_PANEL[IDX_LCLK]        = lclk_q;
    LED_PANEL[IDX_LAT]         = lat_q;
    LED_PANEL[IDX_OE_N]        = oe_n_q;
  end

  assign x        = col_q;
  assign y        = {(phase_q != PH_P0), row_q};
  assign frame    = frame_q;
  assign subframe = subframe_q;

endmodule

// File: tb/tb_led_scanner.sv
// tb/tb_led_scanner.sv - randomized painter and cycle-accurate reference model for led_scanner
module tb_led_scanner;

  localparam int SUB   = 2;
  localparam int ONC   = 64;
  localparam int ROW_P = 256 + 4 + 2 + 1 + ONC;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  rgb = 3'd0;
  logic [12:0] frame;
  logic [7:0]  subframe;
  logic [5:0]  x, y;
  logic [15:0] LED_PANEL;
`ifdef LED_SCANNER_BRIGHTNESS_EN
  logic [2:0]  brightness = 3'd7;
`endif

  int vectors = 0;
  int miscompares = 0;
  int on_len = ONC;
  logic [2:0] pix [0:63][0:63];
  logic [2:0] pend;

  always #5 clk = ~clk;

  led_scanner #(.SUBFRAMES(SUB), .ON_CYCLES(ONC)) dut (
    .clk       (clk),
    .resetn    (resetn),
`ifdef LED_SCANNER_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .frame     (frame),
    .subframe  (subframe),
    .x         (x),
    .y         (y),
    .rgb       (rgb),
    .LED_PANEL (LED_PANEL)
  );

  // painter: answers a query one clock after x/y present it
  initial forever begin
    @(negedge clk);
    pend = pix[y][x];
    @(posedge clk);
    #1 rgb = pend;
  end

  task automatic fill_pix();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        pix[r][c] = 3'($urandom_range(0, 7));
  endtask

  task automatic check_idle(input string tag);
    vectors++;
    if (LED_PANEL !== 16'h2000) begin
      miscompares++;
      $display("FAIL %s panel got %h want %h", tag, LED_PANEL, 16'h2000);
    end
    vectors++;
    if ({x, y, frame, subframe} !== 33'd0) begin
      miscompares++;
      $display("FAIL %s x/y/frame/subframe got %0d/%0d/%0d/%0d want 0", tag, x, y, frame, subframe);
    end
  endtask

  task automatic check_cycle(input int t);
    int ri, pos, row, prow, c;
    logic e_lclk, e_lat, e_oe;
    logic [4:0] e_addr;
    logic [5:0] e_data;
    logic [15:0] e_panel;
    ri   = t / ROW_P;
    pos  = t % ROW_P;
    row  = ri % 32;
    prow = (ri + 31) % 32;
    if (pos < 256) e_lclk = (pos / 4 >= 1) && (pos % 4 == 1 || pos % 4 == 2);
    else           e_lclk = (pos == 257) || (pos == 258);
    e_lat  = (pos == 262);
    e_oe   = !(pos >= 263 && pos - 263 < on_len);
    e_addr = (pos >= 260) ? 5'(row) : ((ri == 0) ? 5'd0 : 5'(prow));
    if (pos < 3) begin
      e_data = (ri == 0) ? 6'd0 : {pix[prow + 32][63], pix[prow][63]};
    end else begin
      c = (pos < 256) ? (pos - 3) / 4 : 63;
      e_data = {pix[row + 32][c], pix[row][c]};
    end
    e_panel = {2'b00, e_oe, e_lat, e_lclk, e_addr, e_data};
    vectors++;
    if (LED_PANEL !== e_panel) begin
      miscompares++;
      $display("FAIL panel t=%0d got %h want %h", t, LED_PANEL, e_panel);
    end
    vectors++;
    if (frame !== 13'((ri / (32 * SUB)) % 8192)) begin
      miscompares++;
      $display("FAIL frame t=%0d got %0d want %0d", t, frame, (ri / (32 * SUB)) % 8192);
    end
    vectors++;
    if (subframe !== 8'((ri / 32) % SUB)) begin
      miscompares++;
      $display("FAIL subframe t=%0d got %0d want %0d", t, subframe, (ri / 32) % SUB);
    end
    if (pos < 256) begin
      vectors++;
      if ({x, y} !== {6'(pos / 4), 6'((pos % 4 == 0) ? row : row + 32)}) begin
        miscompares++;
        $display("FAIL query t=%0d got x=%0d y=%0d want x=%0d y=%0d", t, x, y, pos / 4,
                 (pos % 4 == 0) ? row : row + 32);
      end
    end
  endtask

  // caller has just released resetn on a falling edge: that instant is cycle 0
  task automatic run_scan(input int ncyc);
    int rises = 0;
    int oe_low = 0;
    logic prev_lclk = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      if (t > 0) @(negedge clk);
      check_cycle(t);
      if (LED_PANEL[11] && !prev_lclk) rises++;
      prev_lclk = LED_PANEL[11];
      if (!LED_PANEL[13]) oe_low++;
      if (t % ROW_P == ROW_P - 1) begin
        vectors++;
        if (rises != 64) begin
          miscompares++;
          $display("FAIL lclk_rises t=%0d got %0d want 64", t, rises);
        end
        vectors++;
        if (oe_low != on_len) begin
          miscompares++;
          $display("FAIL oe_low t=%0d got %0d want %0d", t, oe_low, on_len);
        end
        rises = 0;
        oe_low = 0;
      end
    end
  endtask

  task automatic reset_and_release(input string tag);
    @(negedge clk);
    resetn = 1'b0;
    fill_pix();
    repeat (3) begin
      @(negedge clk);
      check_idle(tag);
    end
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    reset_and_release("reset");
    run_scan(2 * ROW_P);
  endtask

  task automatic test_long_then_mid_reset();
    reset_and_release("reset_long");
    run_scan((2 * 32 * SUB + 5) * ROW_P + 20 * 4 + 2);
    #2 resetn = 1'b0;
    #1 check_idle("mid_shift_reset");
    @(negedge clk);
    resetn = 1'b1;
    run_scan(2 * ROW_P);
  endtask

  task automatic test_reset_during_on();
    reset_and_release("reset_on");
    run_scan(ROW_P + 280);
    #2 resetn = 1'b0;
    #1 check_idle("on_reset");
    @(negedge clk);
    resetn = 1'b1;
    run_scan(ROW_P);
  endtask

`ifdef LED_SCANNER_BRIGHTNESS_EN
  task automatic test_brightness(input logic [2:0] b);
    brightness = b;
    on_len = ((int'(b) + 1) * ONC) >> 3;
    reset_and_release("reset_bright");
    run_scan(3 * ROW_P);
  endtask
`endif

  initial begin
    test_reset();
    test_long_then_mid_reset();
    test_reset_during_on();
`ifdef LED_SCANNER_BRIGHTNESS_EN
    test_brightness(3'd3);
    test_brightness(3'd7);
    test_brightness(3'($urandom_range(0, 7)));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
